ray_column_rasterizer: RTL

Parametrised successor to the ray-flattening stage between the DDA output FIFO and the frame buffer. It accepts one DDA ray record per screen column over a valid/ready stream and expands it into one pixel write per row: ceiling, wall or floor, with palette lookup and side shading. Writes are emitted as a backpressured address/pixel stream, and frame ends are marked so the double-buffered frame buffer can swap. Screen geometry and colours are parameters.

---
 rtl/ray_column_rasterizer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ray_column_rasterizer.sv
// ray_column_rasterizer
//   Expands one DDA ray record per screen column into SCREEN_H pixel writes
//   (ceiling / wall / floor), with palette lookup and optional side shading.
//
// Ports
//   pixel_clk_in, rst_n_in          clock, asynchronous active-low reset
//   s_tvalid_in/s_tready_out        record stream handshake
//   s_tdata_in                      {col, height, side, map[3:0], wallx[15:0]}
//   s_tlast_in                      record is the last column of a frame
//   m_tvalid_out/m_tready_in        pixel write stream handshake
//   m_addr_out, m_pixel_out         row*SCREEN_W + col, RGB565 colour
//   m_tlast_out                     final pixel of the frame
//   frame_done_out                  pulse after a frame-last record finishes
//   drop_out                        pulse when an out-of-range column is discarded
module ray_column_rasterizer #(
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 180,
  parameter int unsigned COL_W       = 9,
  parameter int unsigned HGT_W       = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter logic [15:0] CEIL_COLOR  = 16'h4208,
  parameter logic [15:0] FLOOR_COLOR = 16'h2104,
  parameter logic [255:0] PALETTE    = {16'hFFFF, 16'hF7BE, 16'hEF5D, 16'hE71C,
                                        16'hC618, 16'hA514, 16'h8410, 16'h630C,
                                        16'hFFE0, 16'h07FF, 16'hF81F, 16'h001F,
                                        16'h07E0, 16'hF800, 16'hFFFF, 16'h0000},
  parameter bit          SHADE_SIDE  = 1'b1,
  localparam int unsigned DATA_W     = COL_W + HGT_W + 21
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic              s_tvalid_in,
  output logic              s_tready_out,
  input  logic [DATA_W-1:0] s_tdata_in,
  input  logic              s_tlast_in,
  output logic              m_tvalid_out,
  input  logic              m_tready_in,
  output logic [ADDR_W-1:0] m_addr_out,
  output logic [15:0]       m_pixel_out,
  output logic              m_tlast_out,
  output logic              frame_done_out,
  output logic              drop_out
);

  localparam int unsigned ROW_W  = $clog2(SCREEN_H + 1);
  // Span arithmetic must hold both a full height and SCREEN_H itself.
  localparam int unsigned SPAN_W = ((ROW_W > HGT_W) ? ROW_W : HGT_W) + 1;

  localparam logic [ROW_W-1:0]  RowLast   = ROW_W'(SCREEN_H - 1);
  localparam logic [SPAN_W-1:0] ScreenH   = SPAN_W'(SCREEN_H);
  localparam logic [COL_W:0]    ScreenW   = (COL_W + 1)'(SCREEN_W);
  localparam logic [ADDR_W-1:0] RowStride = ADDR_W'(SCREEN_W);

  typedef enum logic {StIdle, StDraw} state_e;

  state_e state_q, state_d;

  logic              rdy_en_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SPAN_W-1:0] top_q, top_d, bot_q, bot_d;
  logic              side_q, side_d;
  logic [3:0]        map_q, map_d;
  logic              tlast_q, tlast_d;
  logic [15:0]       pixel_q, pixel_d;
  logic              mlast_q, mlast_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  // Record fields
  logic [COL_W-1:0]  in_col;
  logic [HGT_W-1:0]  in_hgt;
  logic              in_side;
  logic [3:0]        in_map;
  logic              unused_wallx;

  assign in_col       = s_tdata_in[21 + HGT_W +: COL_W];
  assign in_hgt       = s_tdata_in[21 +: HGT_W];
  assign in_side      = s_tdata_in[20];
  assign in_map       = s_tdata_in[19:16];
  assign unused_wallx = ^s_tdata_in[15:0];

  logic              s_hs, m_hs, last_row, col_ok;
  logic [SPAN_W-1:0] hgt_ext, hc, in_top, in_bot;
  logic [ROW_W-1:0]  row_inc;

  assign s_hs     = s_tvalid_in & s_tready_out;
  assign m_hs     = m_tvalid_out & m_tready_in;
  assign last_row = (row_q == RowLast);
  assign col_ok   = ({1'b0, in_col} < ScreenW);
  assign row_inc  = row_q + 1'b1;

  // Centre the clamped wall span vertically; computed once per record.
  assign hgt_ext = SPAN_W'(in_hgt);
  assign hc      = (hgt_ext > ScreenH) ? ScreenH : hgt_ext;
  assign in_top  = (ScreenH - hc) >> 1;
  assign in_bot  = in_top + hc;

  function automatic logic [15:0] pix_sel(input logic [ROW_W-1:0]  row,
                                          input logic [SPAN_W-1:0] top,
                                          input logic [SPAN_W-1:0] bot,
                                          input logic [3:0]        map,
                                          input logic              side);
    logic [SPAN_W-1:0] r;
    logic [15:0]       c;
    r = SPAN_W'(row);
    c = PALETTE[{map, 4'b0000} +: 16];
    // Halve each RGB565 channel; the mask stops bits leaking across fields.
    if (SHADE_SIDE && side) c = (c >> 1) & 16'h7BEF;
    if (r < top)       pix_sel = CEIL_COLOR;
    else if (r >= bot) pix_sel = FLOOR_COLOR;
    else               pix_sel = c;
  endfunction

  // FSM: state register
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (s_hs && col_ok) state_d = StDraw;
      StDraw: if (m_hs && last_row) state_d = (s_hs && col_ok) ? StDraw : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. The last beat reopens the record port so columns chain
  // back-to-back without a bubble.
  always_comb begin
    m_tvalid_out = (state_q == StDraw);
    s_tready_out = rdy_en_q & ((state_q == StIdle) | (m_tready_in & last_row));
  end

  // Datapath next state
  always_comb begin
    row_d   = row_q;
    addr_d  = addr_q;
    top_d   = top_q;
    bot_d   = bot_q;
    side_d  = side_q;
    map_d   = map_q;
    tlast_d = tlast_q;
    pixel_d = pixel_q;
    mlast_d = mlast_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;

    if (s_hs) begin
      row_d   = '0;
      addr_d  = ADDR_W'(in_col);
      top_d   = in_top;
      bot_d   = in_bot;
      side_d  = in_side;
      map_d   = in_map;
      tlast_d = s_tlast_in;
      pixel_d = pix_sel('0, in_top, in_bot, in_map, in_side);
      mlast_d = s_tlast_in & (RowLast == '0);
      if (!col_ok) begin
        drop_d = 1'b1;
        done_d = s_tlast_in;
      end
    end else if (m_hs && !last_row) begin
      row_d   = row_inc;
      addr_d  = addr_q + RowStride;
      pixel_d = pix_sel(row_inc, top_q, bot_q, map_q, side_q);
      mlast_d = tlast_q & (row_inc == RowLast);
    end

    if (m_hs && last_row && tlast_q) done_d = 1'b1;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_en_q <= 1'b0;
      row_q    <= '0;
      addr_q   <= '0;
      top_q    <= '0;
      bot_q    <= '0;
      side_q   <= 1'b0;
      map_q    <= '0;
      tlast_q  <= 1'b0;
      pixel_q  <= '0;
      mlast_q  <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      row_q    <= row_d;
      addr_q   <= addr_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      side_q   <= side_d;
      map_q    <= map_d;
      tlast_q  <= tlast_d;
      pixel_q  <= pixel_d;
      mlast_q  <= mlast_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign m_addr_out     = addr_q;
  assign m_pixel_out    = pixel_q;
  assign m_tlast_out    = mlast_q;
  assign frame_done_out = done_q;
  assign drop_out       = drop_q;

endmodule
